vector_exec_core: RTL and testbench

//  Self-contained, parametrised execution core; next generation of the IFU/IDU/EXE/ALU unit.

---
 rtl/vector_exec_core_if.sv | 39 +++
 rtl/vector_exec_core.sv | 179 +++++++++++++++++
 tb/tb_vector_exec_core.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vector_exec_core_if.sv
// Bus bundle between vector_exec_core and its code ROM / data RAM / controller.
//  master : the core (drives addresses, write port and status)
//  slave  : the environment (drives trigger, start address, ROM and RAM data)
interface vector_exec_core_if #(
  parameter int unsigned ROM_AW  = 16,
  parameter int unsigned DATA_AW = 8,
  parameter int unsigned ROW_W   = 96,
  parameter int unsigned INSTR_W = 32
);
  logic               iTrigger;
  logic [ROM_AW-1:0]  iInitialCodeAddress;
  logic [ROM_AW-1:0]  oInstructionPointer;
  logic [INSTR_W-1:0] iEncodedInstruction;
  logic [DATA_AW-1:0] oDataReadAddress0;
  logic [DATA_AW-1:0] oDataReadAddress1;
  logic [ROW_W-1:0]   iDataRead0;
  logic [ROW_W-1:0]   iDataRead1;
  logic               oDataWriteEnable;
  logic [DATA_AW-1:0] oDataWriteAddress;
  logic [ROW_W-1:0]   oDataBus;
  logic               oBusy;
  logic               oDone;
  logic               oReturnCode;
  logic               oError;

  modport master (
    input  iTrigger, iInitialCodeAddress, iEncodedInstruction, iDataRead0, iDataRead1,
    output oInstructionPointer, oDataReadAddress0, oDataReadAddress1,
           oDataWriteEnable, oDataWriteAddress, oDataBus,
           oBusy, oDone, oReturnCode, oError
  );

  modport slave (
    output iTrigger, iInitialCodeAddress, iEncodedInstruction, iDataRead0, iDataRead1,
    input  oInstructionPointer, oDataReadAddress0, oDataReadAddress1,
           oDataWriteEnable, oDataWriteAddress, oDataBus,
           oBusy, oDone, oReturnCode, oError
  );
endinterface

// File: rtl/vector_exec_core.sv
// Multi-cycle LANES-wide integer vector core: fetch, operand read, execute/write-back,
// with jumps, lane-0 compare branches and a CALL/RET return stack.
// Ports:
//  clk, rst_n : clock, asynchronous active-low reset
//  bus        : master side of vector_exec_core_if (trigger, ROM/RAM ports, write port, status)
module vector_exec_core #(
  parameter int unsigned LANES       = 3,
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned ROM_AW      = 16,
  parameter int unsigned DATA_AW     = 8,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vector_exec_core_if.master   bus
);

  localparam int unsigned ROW_W   = LANES * WIDTH;
  localparam int unsigned INSTR_W = 8 + 3 * DATA_AW;
  localparam int unsigned SP_W    = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_SUB  = 8'h02;
  localparam logic [7:0] OP_MOV  = 8'h03;
  localparam logic [7:0] OP_AND  = 8'h04;
  localparam logic [7:0] OP_JMP  = 8'h10;
  localparam logic [7:0] OP_JEQ  = 8'h11;
  localparam logic [7:0] OP_JLT  = 8'h12;
  localparam logic [7:0] OP_CALL = 8'h20;
  localparam logic [7:0] OP_RET  = 8'h21;
  localparam logic [7:0] OP_EXIT = 8'h3F;

  typedef enum logic [1:0] {IDLE, FETCH, READ, EXEC} state_t;

  state_t             state;
  logic [ROM_AW-1:0]  ip;
  logic [INSTR_W-1:0] instr;
  logic [SP_W-1:0]    sp;
  logic [ROM_AW-1:0]  retStack [STACK_DEPTH];

  logic [7:0]         opcode;
  logic [DATA_AW-1:0] dst;
  logic [DATA_AW-1:0] src0;
  logic [ROM_AW-1:0]  jumpTarget;
  logic [ROM_AW-1:0]  branchTarget;
  logic [ROM_AW-1:0]  ipNext;
  logic [ROW_W-1:0]   aluResult;
  logic               aluWrite;
  logic               lane0Eq;
  logic               lane0Lt;

  // The IP register is the ROM address; it only changes on entry to FETCH.
  assign bus.oInstructionPointer = ip;

  assign opcode       = instr[INSTR_W-1 -: 8];
  assign dst          = instr[3*DATA_AW-1 -: DATA_AW];
  assign src0         = instr[2*DATA_AW-1 -: DATA_AW];
  assign jumpTarget   = ROM_AW'({dst, src0});
  assign branchTarget = ROM_AW'(dst);
  assign ipNext       = ip + ROM_AW'(1);

  assign aluWrite = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                    (opcode == OP_MOV) || (opcode == OP_AND);
  assign lane0Eq  = bus.iDataRead0[ROW_W-1 -: WIDTH] == bus.iDataRead1[ROW_W-1 -: WIDTH];
  assign lane0Lt  = $signed(bus.iDataRead0[ROW_W-1 -: WIDTH]) <
                    $signed(bus.iDataRead1[ROW_W-1 -: WIDTH]);

  // Per-lane ALU; lanes wrap independently, lane 0 occupies the MSBs.
  always_comb begin
    logic [WIDTH-1:0] laneA;
    logic [WIDTH-1:0] laneB;
    logic [WIDTH-1:0] laneR;
    aluResult = '0;
    laneA     = '0;
    laneB     = '0;
    laneR     = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      laneA = bus.iDataRead0[ROW_W-1-k*WIDTH -: WIDTH];
      laneB = bus.iDataRead1[ROW_W-1-k*WIDTH -: WIDTH];
      case (opcode)
        OP_ADD:  laneR = laneA + laneB;
        OP_SUB:  laneR = laneA - laneB;
        OP_MOV:  laneR = laneA;
        OP_AND:  laneR = laneA & laneB;
        default: laneR = '0;
      endcase
      aluResult[ROW_W-1-k*WIDTH -: WIDTH] = laneR;
    end
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= IDLE;
      ip                    <= '0;
      instr                 <= '0;
      sp                    <= '0;
      for (int i = 0; i < int'(STACK_DEPTH); i++) retStack[i] <= '0;
      bus.oDataReadAddress0 <= '0;
      bus.oDataReadAddress1 <= '0;
      bus.oDataWriteEnable  <= 1'b0;
      bus.oDataWriteAddress <= '0;
      bus.oDataBus          <= '0;
      bus.oBusy             <= 1'b0;
      bus.oDone             <= 1'b0;
      bus.oReturnCode       <= 1'b0;
      bus.oError            <= 1'b0;
    end else begin
      bus.oDataWriteEnable <= 1'b0;
      bus.oDone            <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.iTrigger) begin
            ip              <= bus.iInitialCodeAddress;
            sp              <= '0;
            bus.oReturnCode <= 1'b0;
            bus.oError      <= 1'b0;
            bus.oBusy       <= 1'b1;
            state           <= FETCH;
          end
        end
        FETCH: state <= READ;
        READ: begin
          instr                 <= bus.iEncodedInstruction;
          bus.oDataReadAddress0 <= bus.iEncodedInstruction[2*DATA_AW-1 -: DATA_AW];
          bus.oDataReadAddress1 <= bus.iEncodedInstruction[DATA_AW-1:0];
          state                 <= EXEC;
        end
        EXEC: begin
          state <= FETCH;
          ip    <= ipNext;
          if (aluWrite) begin
            bus.oDataWriteEnable  <= 1'b1;
            bus.oDataWriteAddress <= dst;
            bus.oDataBus          <= aluResult;
          end
          case (opcode)
            OP_JMP: ip <= jumpTarget;
            OP_JEQ: if (lane0Eq) ip <= branchTarget;
            OP_JLT: if (lane0Lt) ip <= branchTarget;
            OP_CALL: begin
              if (sp == SP_W'(STACK_DEPTH)) begin
                bus.oError <= 1'b1;
                bus.oDone  <= 1'b1;
                bus.oBusy  <= 1'b0;
                state      <= IDLE;
              end else begin
                retStack[IDX_W'(sp)] <= ipNext;
                sp                   <= sp + SP_W'(1);
                ip                   <= jumpTarget;
              end
            end
            OP_RET: begin
              if (sp == '0) begin
                bus.oError <= 1'b1;
                bus.oDone  <= 1'b1;
                bus.oBusy  <= 1'b0;
                state      <= IDLE;
              end else begin
                ip <= retStack[IDX_W'(sp - SP_W'(1))];
                sp <= sp - SP_W'(1);
              end
            end
            OP_EXIT: begin
              bus.oReturnCode <= instr[0];
              bus.oDone       <= 1'b1;
              bus.oBusy       <= 1'b0;
              state           <= IDLE;
            end
            default: ;
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_exec_core.sv
// Self-checking bench for vector_exec_core: an instruction-level model predicts the
// fetch trace, write-backs and completion status; a cycle compare process checks the DUT.
module tb_vector_exec_core;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vector_exec_core_if #(.ROM_AW(16), .DATA_AW(8), .ROW_W(96), .INSTR_W(32)) bif ();

  vector_exec_core #(
    .LANES(3), .WIDTH(32), .ROM_AW(16), .DATA_AW(8), .STACK_DEPTH(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif)
  );

  logic [31:0] rom  [256];
  logic [95:0] ram  [256];
  logic [95:0] mram [256];

  // Registered ROM read, combinational RAM read, RAM write on the strobe.
  always @(posedge clk) bif.iEncodedInstruction <= rom[bif.oInstructionPointer[7:0]];
  assign bif.iDataRead0 = ram[bif.oDataReadAddress0];
  assign bif.iDataRead1 = ram[bif.oDataReadAddress1];
  always @(posedge clk) if (bif.oDataWriteEnable) ram[bif.oDataWriteAddress] <= bif.oDataBus;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ins(input logic [7:0] op, input logic [7:0] d,
                                      input logic [7:0] s0, input logic [7:0] s1);
    return {op, d, s0, s1};
  endfunction

  // ---------------- instruction-level model ----------------
  logic [15:0] expIp   [128];
  bit          expWe   [128];
  logic [7:0]  expAddr [128];
  logic [95:0] expData [128];
  int          expN;
  bit          expRc, expErr, expDone;

  task automatic runModel(input logic [15:0] start);
    logic [15:0] ip, nxt;
    logic [15:0] stk [4];
    int          sp;
    logic [7:0]  op, d, s0, s1;
    logic [31:0] a [3];
    logic [31:0] b [3];
    logic [31:0] r [3];
    logic [95:0] rowA, rowB;
    mram = ram;
    expN = 0; expRc = 0; expErr = 0; expDone = 0; sp = 0; ip = start;
    while (!expDone && expN < 100) begin
      {op, d, s0, s1} = rom[ip[7:0]];
      rowA = mram[s0];
      rowB = mram[s1];
      for (int k = 0; k < 3; k++) begin
        a[k] = rowA[95-32*k -: 32];
        b[k] = rowB[95-32*k -: 32];
      end
      expIp[expN] = ip;
      expWe[expN] = 0;
      nxt = ip + 16'd1;
      case (op)
        8'h01, 8'h02, 8'h03, 8'h04: begin
          for (int k = 0; k < 3; k++)
            r[k] = (op == 8'h01) ? a[k] + b[k] : (op == 8'h02) ? a[k] - b[k] :
                   (op == 8'h03) ? a[k] : (a[k] & b[k]);
          expWe[expN]   = 1;
          expAddr[expN] = d;
          expData[expN] = {r[0], r[1], r[2]};
          mram[d]       = {r[0], r[1], r[2]};
        end
        8'h10: nxt = {d, s0};
        8'h11: if (a[0] == b[0]) nxt = {8'h00, d};
        8'h12: if ($signed(a[0]) < $signed(b[0])) nxt = {8'h00, d};
        8'h20: if (sp == 4) begin expErr = 1; expDone = 1; end
               else begin stk[sp] = ip + 16'd1; sp++; nxt = {d, s0}; end
        8'h21: if (sp == 0) begin expErr = 1; expDone = 1; end
               else begin sp--; nxt = stk[sp]; end
        8'h3F: begin expRc = s1[0]; expDone = 1; end
        default: ;
      endcase
      expN++;
      ip = nxt;
    end
  endtask

  // ---------------- cycle compare process ----------------
  int cyc = 0;
  int cmpIdx;
  int doneCycle = -1;
  bit armed = 0;
  bit finished = 0;

  always @(negedge clk) begin
    if (armed) begin
      if (cyc % 3 == 0 && cyc / 3 < expN) begin
        check("fetch_ip", bif.oInstructionPointer, expIp[cyc/3]);
        check("busy", bif.oBusy, 1);
      end
      if (cyc >= 3 && cyc % 3 == 0 && cyc <= 3 * expN) begin
        cmpIdx = cyc / 3 - 1;
        check("write_en", bif.oDataWriteEnable, expWe[cmpIdx]);
        if (expWe[cmpIdx]) begin
          check("write_addr", bif.oDataWriteAddress, expAddr[cmpIdx]);
          check("write_data", bif.oDataBus, expData[cmpIdx]);
        end
      end else begin
        check("write_en_quiet", bif.oDataWriteEnable, 0);
      end
      if (cyc == 3 * expN) begin
        check("done", bif.oDone, 1);
        check("busy_end", bif.oBusy, 0);
        check("return_code", bif.oReturnCode, expRc);
        check("error", bif.oError, expErr);
        doneCycle = cyc;
        armed     = 0;
        finished  = 1;
      end else begin
        check("done_quiet", bif.oDone, 0);
      end
      cyc++;
    end
  end

  // Launch a program; optionally pulse a competing trigger 'poke' cycles in.
  task automatic runProg(input logic [15:0] start, input int poke);
    runModel(start);
    @(negedge clk);
    bif.iInitialCodeAddress = start;
    bif.iTrigger = 1'b1;
    @(posedge clk);
    cyc = 0; finished = 0; doneCycle = -1; armed = 1;
    #1 bif.iTrigger = 1'b0;
    for (int c = 0; c < 3 * expN + 10 && !finished; c++) begin
      @(posedge clk);
      #2;
      bif.iTrigger = (c == poke);
      if (c == poke) bif.iInitialCodeAddress = 16'h00AA;
    end
    bif.iTrigger = 1'b0;
    if (!finished) begin
      checks++; errors++; armed = 0;
      $display("FAIL timeout: got no done expected done by cycle %0d", 3 * expN);
    end
    for (int k = 0; k < 8; k++) check("ram_final", ram[k], mram[k]);
  endtask

  task automatic clearRom();
    for (int i = 0; i < 256; i++) rom[i] = ins(8'h3F, 8'h00, 8'h00, 8'h00);
  endtask

  function automatic logic [31:0] pickLane0();
    case ($urandom_range(0, 4))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      default: return 32'h8000_0000;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1);
  end

  initial begin
    int L, kind, t, tries;
    logic [7:0] op;
    bif.iTrigger = 1'b0;
    bif.iInitialCodeAddress = '0;
    clearRom();
    for (int i = 0; i < 256; i++) ram[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bif.oBusy, 0);
    check("rst_done", bif.oDone, 0);
    check("rst_ip", bif.oInstructionPointer, 0);
    check("rst_we", bif.oDataWriteEnable, 0);
    check("rst_err", bif.oError, 0);
    check("rst_rc", bif.oReturnCode, 0);
    @(negedge clk) rst_n = 1'b1;

    // 1: basic ADD + EXIT 1
    ram[1] = {32'd1, 32'd2, 32'd3};
    ram[2] = {32'd10, 32'd20, 32'd30};
    rom[0] = ins(8'h01, 8'd3, 8'd1, 8'd2);
    rom[1] = ins(8'h3F, 8'd0, 8'd0, 8'd1);
    runProg(16'd0, -1);
    check("t1_ram3", ram[3], {32'd11, 32'd22, 32'd33});
    check("t1_done_cycle", doneCycle, 6);
    check("t1_rc", bif.oReturnCode, 1);

    // 2: lane wrap, no carry into lane 1
    ram[1] = {32'hFFFF_FFFF, 32'd5, 32'd7};
    ram[2] = {32'd1, 32'd2, 32'd3};
    rom[1] = ins(8'h3F, 8'd0, 8'd0, 8'd0);
    runProg(16'd0, -1);
    check("t2_ram3", ram[3], {32'd0, 32'd7, 32'd10});
    check("t2_rc", bif.oReturnCode, 0);

    // 3: signed JLT taken, JEQ not taken, JEQ on equal operands taken
    clearRom();
    ram[4] = {32'hFFFF_FFFF, 32'd0, 32'd0};
    ram[5] = {32'd0, 32'd9, 32'd9};
    rom[0]  = ins(8'h12, 8'd10, 8'd4, 8'd5);
    rom[10] = ins(8'h11, 8'd20, 8'd4, 8'd5);
    rom[11] = ins(8'h11, 8'd30, 8'd4, 8'd4);
    rom[30] = ins(8'h3F, 8'd0, 8'd0, 8'd1);
    runProg(16'd0, -1);
    check("t3_n", expN, 4);
    check("t3_ip1", expIp[1], 16'd10);
    check("t3_ip3", expIp[3], 16'd30);
    check("t3_rc", bif.oReturnCode, 1);

    // 4: four nested CALLs and RETs, then a fifth-level CALL faults
    clearRom();
    rom[0]  = ins(8'h20, 8'd0, 8'd10, 8'd0);
    rom[10] = ins(8'h20, 8'd0, 8'd20, 8'd0);
    rom[20] = ins(8'h20, 8'd0, 8'd30, 8'd0);
    rom[30] = ins(8'h20, 8'd0, 8'd40, 8'd0);
    rom[40] = ins(8'h21, 8'd0, 8'd0, 8'd0);
    rom[31] = ins(8'h21, 8'd0, 8'd0, 8'd0);
    rom[21] = ins(8'h21, 8'd0, 8'd0, 8'd0);
    rom[11] = ins(8'h21, 8'd0, 8'd0, 8'd0);
    rom[1]  = ins(8'h3F, 8'd0, 8'd0, 8'd1);
    runProg(16'd0, -1);
    check("t4_n", expN, 9);
    check("t4_ret_ip", expIp[5], 16'd31);
    check("t4_err", bif.oError, 0);
    rom[50] = ins(8'h20, 8'd0, 8'd60, 8'd0);
    rom[60] = ins(8'h20, 8'd0, 8'd70, 8'd0);
    rom[70] = ins(8'h20, 8'd0, 8'd80, 8'd0);
    rom[80] = ins(8'h20, 8'd0, 8'd90, 8'd0);
    rom[90] = ins(8'h20, 8'd0, 8'd100, 8'd0);
    runProg(16'd50, -1);
    check("t4_overflow_err", bif.oError, 1);
    check("t4_overflow_cycle", doneCycle, 15);

    // 5: RET on empty stack (stack cleared by retrigger), then a clean rerun
    rom[110] = ins(8'h21, 8'd0, 8'd0, 8'd0);
    runProg(16'd110, -1);
    check("t5_err", bif.oError, 1);
    check("t5_cycle", doneCycle, 3);
    runProg(16'd0, -1);
    check("t5_err_cleared", bif.oError, 0);
    check("t5_rc", bif.oReturnCode, 1);

    // IP wrap from 0xFFFF to 0
    clearRom();
    rom[1]   = ins(8'h10, 8'hFF, 8'hFF, 8'd0);
    rom[255] = ins(8'h00, 8'd0, 8'd0, 8'd0);
    rom[0]   = ins(8'h3F, 8'd0, 8'd0, 8'd1);
    runProg(16'd1, -1);
    check("wrap_ip1", expIp[1], 16'hFFFF);
    check("wrap_ip2", expIp[2], 16'h0000);

    // 6: reset during EXEC of an ADD discards the write
    clearRom();
    ram[1] = {32'd4, 32'd5, 32'd6};
    ram[2] = {32'd1, 32'd1, 32'd1};
    ram[3] = {3{32'hDEAD_BEEF}};
    rom[0] = ins(8'h01, 8'd3, 8'd1, 8'd2);
    rom[1] = ins(8'h3F, 8'd0, 8'd0, 8'd1);
    @(negedge clk);
    bif.iInitialCodeAddress = 16'd0;
    bif.iTrigger = 1'b1;
    @(posedge clk);
    #1 bif.iTrigger = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t6_busy", bif.oBusy, 0);
    check("t6_we", bif.oDataWriteEnable, 0);
    check("t6_ip", bif.oInstructionPointer, 0);
    check("t6_raddr", bif.oDataReadAddress0, 0);
    check("t6_waddr", bif.oDataWriteAddress, 0);
    check("t6_bus", bif.oDataBus, 0);
    check("t6_done", bif.oDone, 0);
    repeat (3) @(posedge clk);
    #1 check("t6_no_write", ram[3], {3{32'hDEAD_BEEF}});
    @(negedge clk) rst_n = 1'b1;
    // Trigger while busy is ignored
    runProg(16'd0, 0);
    check("t6_rerun_ram3", ram[3], {32'd5, 32'd6, 32'd7});

    // Randomized programs with forward control flow
    tries = 0;
    for (int p = 0; p < 40 && tries < 400; tries++) begin
      clearRom();
      for (int k = 0; k < 8; k++) ram[k] = {pickLane0(), $urandom(), $urandom()};
      L = $urandom_range(4, 14);
      for (int a = 0; a < L; a++) begin
        kind = $urandom_range(0, 9);
        t = $urandom_range(a + 1, L);
        case (kind)
          0: rom[a] = ins(($urandom_range(0, 1) != 0) ? 8'h00 : 8'h55, 8'($urandom_range(0, 7)),
                          8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)));
          4: rom[a] = ins(($urandom_range(0, 1) != 0) ? 8'h11 : 8'h12, 8'(t),
                          8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)));
          5: rom[a] = ins(8'h10, 8'd0, 8'(t), 8'd0);
          6: rom[a] = ins(8'h20, 8'd0, 8'(t), 8'd0);
          7: rom[a] = ins(8'h21, 8'd0, 8'd0, 8'd0);
          default: begin
            op = 8'($urandom_range(1, 4));
            rom[a] = ins(op, 8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)),
                         8'($urandom_range(0, 7)));
          end
        endcase
      end
      rom[L] = ins(8'h3F, 8'd0, 8'd0, 8'($urandom_range(0, 1)));
      runModel(16'd0);
      if (expDone) begin
        runProg(16'd0, ($urandom_range(0, 3) == 0) ? 0 : -1);
        p++;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
